// File: rtl/tron_types_pkg.sv
// Shared types and helpers for the light-cycle arena engine.
package tron_types_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    ST_BOOT,
    ST_CLEAR,
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_STEP,
    ST_HEAD,
    ST_SEL,
    ST_RD,
    ST_CHK,
    ST_WR,
    ST_EVAL,
    ST_GAME_OVER
  } arena_state_t;

  localparam int CELL_EMPTY = 0;

  // Opposite directions differ only in the upper encoding bit.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({~d[1], d[0]});
  endfunction

  function automatic int start_x(input int p, input int grid_w, input int num_players);
    return (grid_w * (2 * p + 1)) / (2 * num_players);
  endfunction

endpackage

// File: rtl/tron_tick_gen.sv
// Movement tick divider with a sticky pending flag.
module tron_tick_gen #(
  parameter int TICK_DIV = 1500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic hold,
  input  logic clear,
  output logic pending
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  assign wrap = !hold && (cnt_q == CNT_W'(TICK_DIV - 1));

  // NOTE: flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      pending <= 1'b0;
    end else begin
      if (hold || wrap) cnt_q <= '0;
      else              cnt_q <= cnt_q + CNT_W'(1);
      // A wrap coinciding with the consume keeps the new tick.
      if (wrap)       pending <= 1'b1;
      else if (clear) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/tron_arena_engine.sv
// N-player light-cycle engine: clears the frame RAM, steps cycles per tick, judges crashes.
// Define TRON_ARENA_WRAP_EN for a toroidal arena without lethal borders.
module tron_arena_engine
  import tron_types_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int GRID_W      = 320,
  parameter int GRID_H      = 240,
  parameter int TICK_DIV    = 1500000,
  parameter int ADDR_W      = 19,
  parameter int CELL_W      = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [2*NUM_PLAYERS-1:0] dir_i,
  output logic [ADDR_W-1:0]        ram_addr_o,
  input  logic [CELL_W-1:0]        ram_rdata_i,
  output logic                     ram_we_o,
  output logic [CELL_W-1:0]        ram_wdata_o,
  output logic [NUM_PLAYERS-1:0]   alive_o,
  output logic                     game_over_o,
  output logic [CELL_W-1:0]        winner_o
);
  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int CUR_W = $clog2(NUM_PLAYERS + 1);
  localparam int IDX_W = $clog2(NUM_PLAYERS);
  localparam int CELLS = GRID_W * GRID_H;
`ifdef TRON_ARENA_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  arena_state_t           state_q, state_d;
  logic [X_W-1:0]         head_x_q [NUM_PLAYERS];
  logic [Y_W-1:0]         head_y_q [NUM_PLAYERS];
  dir_t                   dir_q    [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] alive_q;
  logic [CUR_W-1:0]       cursor_q;
  logic [ADDR_W-1:0]      clr_q;
  logic [CELL_W-1:0]      winner_q;

  logic                   tick_pending;
  logic [IDX_W-1:0]       cur_idx;
  logic [X_W-1:0]         cur_x;
  logic [Y_W-1:0]         cur_y;
  logic [ADDR_W-1:0]      cur_addr;
  logic                   cur_done;
  logic                   crash;
  logic [NUM_PLAYERS-1:0] head_kill;
  logic [CUR_W-1:0]       live_cnt;
  logic [CELL_W-1:0]      survivor;

  tron_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .hold    (state_q == ST_IDLE),
    .clear   (state_q == ST_WAIT && tick_pending),
    .pending (tick_pending)
  );

  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input dir_t d);
    step_x = x;
    if (d == DIR_RIGHT)     step_x = (WRAP_EN && x == X_W'(GRID_W - 1)) ? '0 : x + X_W'(1);
    else if (d == DIR_LEFT) step_x = (WRAP_EN && x == '0) ? X_W'(GRID_W - 1) : x - X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input dir_t d);
    step_y = y;
    if (d == DIR_DOWN)    step_y = (WRAP_EN && y == Y_W'(GRID_H - 1)) ? '0 : y + Y_W'(1);
    else if (d == DIR_UP) step_y = (WRAP_EN && y == '0) ? Y_W'(GRID_H - 1) : y - Y_W'(1);
  endfunction

  assign cur_idx  = cursor_q[IDX_W-1:0];
  assign cur_done = (cursor_q == CUR_W'(NUM_PLAYERS));
  assign cur_x    = head_x_q[cur_idx];
  assign cur_y    = head_y_q[cur_idx];
  assign cur_addr = ADDR_W'(32'(cur_y) * 32'(GRID_W) + 32'(cur_x));

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    crash = (ram_rdata_i != CELL_W'(CELL_EMPTY));
    if (!WRAP_EN && (cur_x == '0 || cur_x == X_W'(GRID_W - 1) ||
                     cur_y == '0 || cur_y == Y_W'(GRID_H - 1)))
      crash = 1'b1;
  end

  always_comb begin
    head_kill = '0;
    for (int a = 0; a < NUM_PLAYERS; a++)
      for (int b = a + 1; b < NUM_PLAYERS; b++)
        if (alive_q[a] && alive_q[b] &&
            head_x_q[a] == head_x_q[b] && head_y_q[a] == head_y_q[b]) begin
          head_kill[a] = 1'b1;
          head_kill[b] = 1'b1;
        end
  end

  always_comb begin
    live_cnt = '0;
    survivor = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (alive_q[p]) begin
        live_cnt = live_cnt + CUR_W'(1);
        survivor = CELL_W'(p + 1);
      end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:      state_d = ST_CLEAR;
      ST_CLEAR:     if (clr_q == ADDR_W'(CELLS - 1)) state_d = ST_INIT;
      ST_INIT:      state_d = ST_IDLE;
      ST_IDLE:      if (start_i) state_d = ST_WAIT;
      ST_WAIT:      if (tick_pending) state_d = ST_STEP;
      ST_STEP:      state_d = ST_HEAD;
      ST_HEAD:      state_d = ST_SEL;
      ST_SEL:       if (cur_done) state_d = ST_EVAL;
                    else if (alive_q[cur_idx]) state_d = ST_RD;
      ST_RD:        state_d = ST_CHK;
      ST_CHK:       state_d = crash ? ST_SEL : ST_WR;
      ST_WR:        state_d = ST_SEL;
      ST_EVAL:      state_d = (live_cnt <= CUR_W'(1)) ? ST_GAME_OVER : ST_WAIT;
      ST_GAME_OVER: if (start_i) state_d = ST_CLEAR;
      default:      state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  // NOTE: the frame RAM itself has no reset; the CLEAR sweep empties it after every release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        head_x_q[p] <= '0;
        head_y_q[p] <= '0;
        dir_q[p]    <= DIR_UP;
      end
      alive_q  <= '0;
      cursor_q <= '0;
      clr_q    <= '0;
      winner_q <= '0;
    end else begin
      clr_q <= (state_q == ST_CLEAR) ? clr_q + ADDR_W'(1) : '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (state_q == ST_INIT)
          dir_q[p] <= (p % 2 == 0) ? DIR_RIGHT : DIR_LEFT;
        else if (dir_t'(dir_i[2*p +: 2]) != opposite(dir_q[p]))
          dir_q[p] <= dir_t'(dir_i[2*p +: 2]);
      end
      case (state_q)
        ST_INIT: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            head_x_q[p] <= X_W'(start_x(p, GRID_W, NUM_PLAYERS));
            head_y_q[p] <= Y_W'(GRID_H / 2);
          end
          alive_q  <= '1;
          cursor_q <= '0;
          winner_q <= '0;
        end
        ST_STEP:
          for (int p = 0; p < NUM_PLAYERS; p++)
            if (alive_q[p]) begin
              head_x_q[p] <= step_x(head_x_q[p], dir_q[p]);
              head_y_q[p] <= step_y(head_y_q[p], dir_q[p]);
            end
        ST_HEAD: begin
          alive_q  <= alive_q & ~head_kill;
          cursor_q <= '0;
        end
        ST_SEL:  if (!cur_done && !alive_q[cur_idx]) cursor_q <= cursor_q + CUR_W'(1);
        ST_CHK:  if (crash) alive_q[cur_idx] <= 1'b0;
        ST_WR:   cursor_q <= cursor_q + CUR_W'(1);
        ST_EVAL: if (live_cnt <= CUR_W'(1)) winner_q <= survivor;
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state_q)
      ST_CLEAR: begin
        ram_we_o    = 1'b1;
        ram_addr_o  = clr_q;
        ram_wdata_o = CELL_W'(CELL_EMPTY);
      end
      ST_RD: ram_addr_o = cur_addr;
      ST_WR: begin
        ram_we_o    = 1'b1;
        ram_addr_o  = cur_addr;
        ram_wdata_o = CELL_W'(cursor_q) + CELL_W'(1);
      end
      default: ;
    endcase
  end

  assign alive_o     = alive_q;
  assign game_over_o = (state_q == ST_GAME_OVER);
  assign winner_o    = winner_q;

endmodule

// File: tb/tb_tron_arena_engine.sv
// Self-checking bench for tron_arena_engine on a 16x12 arena with two players.
module tb_tron_arena_engine;
  import tron_types_pkg::*;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int N  = 2;
  localparam int TD = 8;
  localparam int AW = 8;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [2*N-1:0] dir_i = {DIR_LEFT, DIR_RIGHT};
  logic [AW-1:0] ram_addr_o;
  logic [CW-1:0] ram_rdata_i = '0;
  logic          ram_we_o;
  logic [CW-1:0] ram_wdata_o;
  logic [N-1:0]  alive_o;
  logic          game_over_o;
  logic [CW-1:0] winner_o;

  tron_arena_engine #(
    .NUM_PLAYERS(N), .GRID_W(W), .GRID_H(H), .TICK_DIV(TD), .ADDR_W(AW), .CELL_W(CW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .dir_i       (dir_i),
    .ram_addr_o  (ram_addr_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_we_o    (ram_we_o),
    .ram_wdata_o (ram_wdata_o),
    .alive_o     (alive_o),
    .game_over_o (game_over_o),
    .winner_o    (winner_o)
  );

  always #5 clock = ~clock;

  // Frame RAM with one-cycle synchronous read.
  logic [CW-1:0] mem [256];
  always @(posedge clock) begin
    if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
    ram_rdata_i <= mem[ram_addr_o];
  end

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t wq[$];
  int  cyc = 0;
  always @(negedge clock) begin
    if (reset_n && ram_we_o) wq.push_back('{int'(ram_addr_o), int'(ram_wdata_o), cyc});
    cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic get_write(output wr_t w, output bit ok);
    int waited = 0;
    ok = 1'b0;
    w  = '{0, 0, 0};
    while (wq.size() == 0 && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    check("write_arrived", wq.size() > 0, 1);
    if (wq.size() > 0) begin
      w  = wq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic expect_wr(input string name, input int addr, input int data);
    wr_t w;
    bit  ok;
    get_write(w, ok);
    if (ok) begin
      check({name, "_addr"}, w.addr, addr);
      check({name, "_data"}, w.data, data);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_we"}, ram_we_o, 0);
    check({name, "_addr"}, ram_addr_o, 0);
    check({name, "_wdata"}, ram_wdata_o, 0);
    check({name, "_alive"}, alive_o, 0);
    check({name, "_over"}, game_over_o, 0);
    check({name, "_winner"}, winner_o, 0);
  endtask

  task automatic expect_clear();
    wr_t w;
    bit  ok;
    int  first_cyc = 0;
    for (int i = 0; i < W * H; i++) begin
      get_write(w, ok);
      if (!ok) return;
      if (i == 0) first_cyc = w.cyc;
      check("clear_addr", w.addr, i);
      check("clear_data", w.data, 0);
      check("clear_contiguous", w.cyc - first_cyc, i);
    end
  endtask

  task automatic expect_idle();
    repeat (4) @(negedge clock);
    check("idle_alive", alive_o, 2'b11);
    check("idle_we", ram_we_o, 0);
    check("idle_over", game_over_o, 0);
    check("idle_no_writes", wq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    dir_i   = {DIR_LEFT, DIR_RIGHT};
    start_i = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_quiet("reset");
    reset_n = 1'b1;
    wq.delete();
    #1 check("boot_we", ram_we_o, 0);
    expect_clear();
    expect_idle();
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
  endtask

  task automatic wait_over();
    int n = 0;
    while (!game_over_o && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("game_over", game_over_o, 1);
  endtask

  // Reference game: positions, directions and an occupancy grid, one tick at a time.
  task automatic play_random_game();
    int   mx[N], my[N], grid[W*H], kill[N];
    dir_t md[N], rq[N];
    bit   ma[N];
    bit   over = 1'b0;
    int   tick = 0, live, win, dx, dy;
    for (int i = 0; i < W * H; i++) grid[i] = 0;
    for (int p = 0; p < N; p++) begin
      mx[p] = (W * (2 * p + 1)) / (2 * N);
      my[p] = H / 2;
      md[p] = (p % 2 == 1) ? DIR_LEFT : DIR_RIGHT;
      ma[p] = 1'b1;
      rq[p] = dir_t'($urandom_range(3));
      if (!((rq[p] == DIR_UP && md[p] == DIR_DOWN) || (rq[p] == DIR_DOWN && md[p] == DIR_UP) ||
            (rq[p] == DIR_LEFT && md[p] == DIR_RIGHT) || (rq[p] == DIR_RIGHT && md[p] == DIR_LEFT)))
        md[p] = rq[p];
    end
    @(negedge clock);
    dir_i = {rq[1], rq[0]};
    pulse_start();
    while (!over && tick < 300) begin
      tick++;
      for (int p = 0; p < N; p++) begin
        if (!ma[p]) continue;
        dx = (md[p] == DIR_RIGHT) ? 1 : (md[p] == DIR_LEFT) ? -1 : 0;
        dy = (md[p] == DIR_DOWN)  ? 1 : (md[p] == DIR_UP)   ? -1 : 0;
`ifdef TRON_ARENA_WRAP_EN
        mx[p] = (mx[p] + dx + W) % W;
        my[p] = (my[p] + dy + H) % H;
`else
        mx[p] = mx[p] + dx;
        my[p] = my[p] + dy;
`endif
      end
      for (int p = 0; p < N; p++) kill[p] = 0;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++)
          if (a != b && ma[a] && ma[b] && mx[a] == mx[b] && my[a] == my[b]) kill[a] = 1;
      for (int p = 0; p < N; p++) if (kill[p] != 0) ma[p] = 1'b0;
      for (int p = 0; p < N; p++) begin
        if (!ma[p]) continue;
`ifdef TRON_ARENA_WRAP_EN
        if (grid[my[p] * W + mx[p]] != 0) ma[p] = 1'b0;
`else
        if (mx[p] == 0 || mx[p] == W - 1 || my[p] == 0 || my[p] == H - 1 ||
            grid[my[p] * W + mx[p]] != 0) ma[p] = 1'b0;
`endif
        if (ma[p]) begin
          grid[my[p] * W + mx[p]] = p + 1;
          expect_wr("rand_wr", my[p] * W + mx[p], p + 1);
        end
      end
      live = 0;
      win  = 0;
      for (int p = 0; p < N; p++) if (ma[p]) begin live++; win = p + 1; end
      if (live <= 1) over = 1'b1;
      else begin
        for (int p = 0; p < N; p++) begin
          if ($urandom_range(2) == 0) rq[p] = dir_t'($urandom_range(3));
          if (!((rq[p] == DIR_UP && md[p] == DIR_DOWN) || (rq[p] == DIR_DOWN && md[p] == DIR_UP) ||
                (rq[p] == DIR_LEFT && md[p] == DIR_RIGHT) || (rq[p] == DIR_RIGHT && md[p] == DIR_LEFT)))
            md[p] = rq[p];
        end
        dir_i = {rq[1], rq[0]};
      end
    end
    wait_over();
    check("rand_winner", winner_o, (live == 1) ? win : 0);
    check("rand_alive", alive_o, {ma[1], ma[0]});
  endtask

  typedef struct { dir_t d0; dir_t d1; int a0; int a1; } vec_t;
  vec_t vt[5];

  initial begin
    vt[0] = '{DIR_RIGHT, DIR_LEFT,  101, 107};
    vt[1] = '{DIR_LEFT,  DIR_RIGHT, 101, 107};
    vt[2] = '{DIR_UP,    DIR_DOWN,   84, 124};
    vt[3] = '{DIR_DOWN,  DIR_UP,    116,  92};
    vt[4] = '{DIR_UP,    DIR_LEFT,   84, 107};

    // First tick for a table of initial steering requests.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      dir_i = {vt[i].d1, vt[i].d0};
      repeat (2) @(negedge clock);
      pulse_start();
      expect_wr("vec_p0", vt[i].a0, 1);
      expect_wr("vec_p1", vt[i].a1, 2);
    end

    // Turn P0 up after the first tick.
    do_reset();
    pulse_start();
    expect_wr("turn_t1_p0", 101, 1);
    expect_wr("turn_t1_p1", 107, 2);
    dir_i = {DIR_LEFT, DIR_UP};
    expect_wr("turn_t2_p0", 85, 1);
    expect_wr("turn_t2_p1", 106, 2);

    // Head-on collision at (8,6): draw.
    do_reset();
    pulse_start();
    expect_wr("ho_t1_p0", 101, 1);
    expect_wr("ho_t1_p1", 107, 2);
    expect_wr("ho_t2_p0", 102, 1);
    expect_wr("ho_t2_p1", 106, 2);
    expect_wr("ho_t3_p0", 103, 1);
    expect_wr("ho_t3_p1", 105, 2);
    wait_over();
    check("ho_winner", winner_o, 0);
    check("ho_alive", alive_o, 0);
    check("ho_no_wr", wq.size(), 0);
    repeat (20) @(negedge clock);
    check("ho_hold_over", game_over_o, 1);
    check("ho_hold_we", ram_we_o, 0);

    // P0 runs straight up into the top border (or wraps around it).
    do_reset();
    dir_i = {DIR_LEFT, DIR_UP};
    pulse_start();
    for (int t = 1; t <= 5; t++) begin
      expect_wr("up_p0", (6 - t) * W + 4, 1);
      expect_wr("up_p1", 6 * W + 12 - t, 2);
    end
`ifdef TRON_ARENA_WRAP_EN
    expect_wr("up_t6_p0", 4, 1);
    expect_wr("up_t6_p1", 102, 2);
    expect_wr("up_t7_p0", 11 * W + 4, 1);
    expect_wr("up_t7_p1", 101, 2);
`else
    expect_wr("up_t6_p1", 102, 2);
    wait_over();
    check("up_winner", winner_o, 2);
    check("up_alive", alive_o, 2'b10);
`endif

    // Reset asserted during CHK: outputs drop at once, then the sweep repeats.
    do_reset();
    pulse_start();
    begin
      int n = 0;
      while (!(ram_we_o == 1'b0 && ram_addr_o != 0) && n < 500) begin
        @(negedge clock);
        n++;
      end
      check("rd_seen", (ram_we_o == 1'b0 && ram_addr_o != 0), 1);
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1 check_quiet("mid_reset");
    repeat (2) @(negedge clock);
    dir_i   = {DIR_LEFT, DIR_RIGHT};
    reset_n = 1'b1;
    wq.delete();
    expect_clear();
    expect_idle();

    // Random games, each new round started from GAME_OVER.
    for (int g = 0; g < 6; g++) begin
      play_random_game();
      @(negedge clock);
      dir_i = {DIR_LEFT, DIR_RIGHT};
      wq.delete();
      pulse_start();
      expect_clear();
      expect_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
